// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the reduced RISC-V core (addi, bne, lw).
// Shares one memory port between instruction fetch and data load, with a request timeout.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       instr_opcode,
  input  logic             EQ,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic             RegWrite,
  output logic [2:0]       ALUctrl,
  output logic             ALUsrc,
  output logic             ImmSrc,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEMRD  = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd7
  } state_e;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) + 1 : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               err_q, err_d;
  logic               timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timeout = (MEM_TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_LIM);
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (mem_ready)    state_d = DECODE;
        else if (timeout) state_d = ERROR;
      end
      DECODE: begin
        if (instr_opcode == OP_ADDI || instr_opcode == OP_BNE || instr_opcode == OP_LW)
          state_d = EXEC;
        else
          state_d = ERROR;
      end
      EXEC: begin
        case (instr_opcode)
          OP_ADDI: state_d = WB;
          OP_LW:   state_d = MEMRD;
          OP_BNE:  state_d = FETCH;
          default: state_d = ERROR;
        endcase
      end
      MEMRD: begin
        if (mem_ready)    state_d = WB;
        else if (timeout) state_d = ERROR;
      end
      WB:      state_d = FETCH;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    // Wait counter restarts on every fresh memory request and saturates rather than wrapping.
    wait_d = wait_q;
    if ((state_d == FETCH || state_d == MEMRD) && state_d != state_q)
      wait_d = '0;
    else if ((state_q == FETCH || state_q == MEMRD) && !mem_ready && wait_q != WAIT_MAX)
      wait_d = wait_q + 1'b1;

    err_d     = (state_d == ERROR);
    retired_d = retired_q + CNT_W'(PCWrite);
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_sel  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    RegWrite = 1'b0;
    ALUctrl  = 3'b000;
    ALUsrc   = 1'b0;
    ImmSrc   = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
      end
      EXEC: begin
        if (instr_opcode == OP_BNE) begin
          ALUctrl = 3'b111;
          PCWrite = 1'b1;
          PCsrc   = ~EQ;
        end else begin
          ALUsrc = 1'b1;
          ImmSrc = 1'b1;
        end
      end
      MEMRD: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        ALUsrc  = 1'b1;
        ImmSrc  = 1'b1;
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of per-cycle vectors followed by
// hand-written sequences for error dwell, timeout and asynchronous reset.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_BAD  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  instrOpcode = OP_ADDI;
  logic        eqFlag = 1'b0;
  logic        memReady = 1'b0;
  logic        memReq, memSel, irWrite, pcWrite, pcSrc, regWrite, aluSrc, immSrc, errFlag;
  logic [2:0]  aluCtrl, stateOut;
  logic [15:0] retiredCnt;
  logic [14:0] obs;

  int compared = 0;
  int mismatched = 0;

  // Packed order: state, mem_req, mem_sel, IRWrite, PCWrite, PCsrc, RegWrite, ALUctrl, ALUsrc, ImmSrc, err
  typedef struct {
    logic        rstN;
    logic [6:0]  op;
    logic        eq;
    logic        rdy;
    logic [14:0] expOuts;
    logic [15:0] expRet;
  } vec_t;

  vec_t vecs[$];

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_opcode(instrOpcode), .EQ(eqFlag), .mem_ready(memReady),
    .mem_req(memReq), .mem_sel(memSel), .IRWrite(irWrite), .PCWrite(pcWrite), .PCsrc(pcSrc),
    .RegWrite(regWrite), .ALUctrl(aluCtrl), .ALUsrc(aluSrc), .ImmSrc(immSrc),
    .state(stateOut), .err(errFlag), .retired(retiredCnt)
  );

  always #5 clk = ~clk;

  assign obs = {stateOut, memReq, memSel, irWrite, pcWrite, pcSrc, regWrite, aluCtrl, aluSrc, immSrc, errFlag};

  function automatic vec_t v(input logic r, input logic [6:0] op, input logic e, input logic rd,
                             input logic [2:0] st, input logic mr, input logic ms, input logic irw,
                             input logic pcw, input logic pcs, input logic rw, input logic [2:0] alu,
                             input logic as, input logic is, input logic er, input logic [15:0] ret);
    vec_t x;
    x.rstN = r; x.op = op; x.eq = e; x.rdy = rd;
    x.expOuts = {st, mr, ms, irw, pcw, pcs, rw, alu, as, is, er};
    x.expRet = ret;
    return x;
  endfunction

  task automatic applyStimulus(input logic r, input logic [6:0] op, input logic e, input logic rd);
    rst = r;
    instrOpcode = op;
    eqFlag = e;
    memReady = rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [6:0] op, input logic e, input logic rd);
    @(negedge clk);
    applyStimulus(r, op, e, rd);
    #1;
  endtask

  initial begin
    // rst op eq rdy | st mr ms irw pcw pcs rw alu as is er | retired
    vecs.push_back(v(0, OP_ADDI, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 0, 0, 3'd1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 0, 0, 3'd1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 0, 1, 3'd1, 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 0, 0, 3'd3, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 16'd0));
    vecs.push_back(v(1, OP_ADDI, 1, 0, 3'd5, 0, 0, 0, 1, 0, 1, 3'b000, 0, 0, 0, 16'd0));
    vecs.push_back(v(1, OP_BNE,  0, 1, 3'd1, 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 16'd1));
    vecs.push_back(v(1, OP_BNE,  0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd1));
    vecs.push_back(v(1, OP_BNE,  0, 0, 3'd3, 0, 0, 0, 1, 1, 0, 3'b111, 0, 0, 0, 16'd1));
    vecs.push_back(v(1, OP_BNE,  1, 1, 3'd1, 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 16'd2));
    vecs.push_back(v(1, OP_BNE,  1, 0, 3'd2, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd2));
    vecs.push_back(v(1, OP_BNE,  1, 0, 3'd3, 0, 0, 0, 1, 0, 0, 3'b111, 0, 0, 0, 16'd2));
    vecs.push_back(v(1, OP_LW,   0, 1, 3'd1, 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 0, 3'd3, 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 0, 3'd4, 1, 1, 0, 0, 0, 0, 3'b000, 1, 1, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 0, 3'd4, 1, 1, 0, 0, 0, 0, 3'b000, 1, 1, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 0, 3'd4, 1, 1, 0, 0, 0, 0, 3'b000, 1, 1, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 1, 3'd4, 1, 1, 0, 0, 0, 0, 3'b000, 1, 1, 0, 16'd3));
    vecs.push_back(v(1, OP_LW,   0, 0, 3'd5, 0, 0, 0, 1, 0, 1, 3'b000, 0, 0, 0, 16'd3));
    vecs.push_back(v(1, OP_BAD,  0, 1, 3'd1, 1, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 16'd4));
    vecs.push_back(v(1, OP_BAD,  0, 0, 3'd2, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 16'd4));
    vecs.push_back(v(1, OP_BAD,  0, 0, 3'd7, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 16'd4));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rstN, vecs[i].op, vecs[i].eq, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_outs", i), 32'(obs), 32'(vecs[i].expOuts));
      checkOutput($sformatf("vec%0d_retired", i), 32'(retiredCnt), 32'(vecs[i].expRet));
    end

    // ERROR must hold for good, ignoring mem_ready, with retired frozen
    for (int i = 0; i < 20; i++) begin
      cycle(1, OP_BAD, 0, 1);
      checkOutput($sformatf("errDwell%0d", i), 32'({stateOut, memReq, errFlag, retiredCnt}),
                  32'({3'd7, 1'b0, 1'b1, 16'd4}));
    end

    @(negedge clk);
    #2 rst = 1'b0;
    #1 checkOutput("errResetAsync", 32'({stateOut, errFlag}), 32'({3'd0, 1'b0}));
    cycle(0, OP_ADDI, 0, 0);

    // Timeout: mem_ready never arrives in FETCH
    cycle(1, OP_ADDI, 0, 0);
    checkOutput("toIdle", 32'(stateOut), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, OP_ADDI, 0, 0);
      checkOutput($sformatf("toFetch%0d", i), 32'({stateOut, memReq, errFlag}), 32'({3'd1, 1'b1, 1'b0}));
    end
    cycle(1, OP_ADDI, 0, 0);
    checkOutput("toError", 32'({stateOut, memReq, errFlag}), 32'({3'd7, 1'b0, 1'b1}));

    // Timeout boundary: ready on the last allowed cycle wins
    cycle(0, OP_ADDI, 0, 0);
    cycle(0, OP_ADDI, 0, 0);
    checkOutput("rstHeld", 32'({stateOut, errFlag, retiredCnt}), 32'({3'd0, 1'b0, 16'd0}));
    cycle(1, OP_ADDI, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, OP_ADDI, 0, 0);
      checkOutput($sformatf("edgeFetch%0d", i), 32'({stateOut, irWrite}), 32'({3'd1, 1'b0}));
    end
    cycle(1, OP_ADDI, 0, 1);
    checkOutput("edgeFetchReady", 32'({stateOut, irWrite}), 32'({3'd1, 1'b1}));
    cycle(1, OP_LW, 0, 0);
    checkOutput("edgeDecode", 32'({stateOut, errFlag}), 32'({3'd2, 1'b0}));

    // Async reset in the middle of a pending load
    cycle(1, OP_LW, 0, 0);
    checkOutput("arExec", 32'(stateOut), 32'd3);
    cycle(1, OP_LW, 0, 0);
    checkOutput("arMemrd", 32'({stateOut, memReq, memSel}), 32'({3'd4, 1'b1, 1'b1}));
    #2 rst = 1'b0;
    #1 checkOutput("arDrop", 32'({stateOut, memReq, regWrite, errFlag, retiredCnt}),
                   32'({3'd0, 1'b0, 1'b0, 1'b0, 16'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
